// File: rtl/ofdm_sym_pkg.sv
// Shared OFDM symbol definitions: modulation encodings, constellation levels and
// the hard-decision slicing thresholds derived from them.
package ofdm_sym_pkg;

   typedef enum logic [1:0] {
      MOD_QPSK = 2'b00,
      MOD_BPSK = 2'b01,
      MOD_Q16  = 2'b10,
      MOD_Q64  = 2'b11
   } mod_t;

   // Positive constellation levels in Q1.15 (the outermost 64QAM level is saturated)
   localparam logic [15:0] Q64_L1 = 16'h13C0;
   localparam logic [15:0] Q64_L3 = 16'h3B40;
   localparam logic [15:0] Q64_L5 = 16'h62C2;
   localparam logic [15:0] Q64_L7 = 16'h7FFE;
   localparam logic [15:0] Q16_L1 = 16'h287A;
   localparam logic [15:0] Q16_L3 = 16'h796E;

   function automatic logic [15:0] midpoint(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16:1];
   endfunction

   localparam logic [15:0] Q64_T1 = midpoint(Q64_L1, Q64_L3);
   localparam logic [15:0] Q64_T2 = midpoint(Q64_L3, Q64_L5);
   localparam logic [15:0] Q64_T3 = midpoint(Q64_L5, Q64_L7);
   localparam logic [15:0] Q16_T  = midpoint(Q16_L1, Q16_L3);

endpackage

// File: rtl/sym_demod_if.sv
// WB-style streaming handshake bundle, used for both the sample input and bit output.
interface sym_demod_if #(
   parameter int unsigned DW = 32
) ();
   logic [DW-1:0] DAT;
   logic          CYC;
   logic          STB;
   logic          WE;
   logic          ACK;

   modport master (output DAT, output CYC, output STB, output WE, input ACK);
   modport slave  (input DAT, input CYC, input STB, input WE, output ACK);
endinterface

// File: rtl/sym_slicer_axis.sv
// Per-axis slicer: sign plus threshold compares on the 17-bit magnitude of one Q1.15 sample.
module sym_slicer_axis
   import ofdm_sym_pkg::*;
(
   input  logic [15:0] x,
   input  mod_t        mod,
   output logic        sgn,
   output logic [2:0]  cmp
);

   logic [16:0] mag;

   // 17-bit magnitude so that 16'h8000 slices as +32768 rather than wrapping
   always_comb begin
      sgn    = x[15];
      mag    = x[15] ? (17'd0 - {x[15], x}) : {1'b0, x};
      cmp[2] = mag > {1'b0, Q64_T3};
      cmp[1] = mag > {1'b0, Q64_T2};
      cmp[0] = (mod == MOD_Q16) ? (mag > {1'b0, Q16_T}) : (mag > {1'b0, Q64_T1});
   end

endmodule

// File: rtl/sym_demod.sv
// Hard-decision Gray demapper (BPSK/QPSK/16QAM/64QAM), 2-stage pipeline, freezes on backpressure.
module sym_demod
   import ofdm_sym_pkg::*;
(
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic [1:0]  MOD,
   sym_demod_if.slave  rx,
   sym_demod_if.master tx
);

   logic       halt, beat, accept;
   logic       locked;
   mod_t       mod_lat, mod_cur;
   logic       re_s, im_s;
   logic [2:0] re_c, im_c;

   logic       s1_v;
   mod_t       s1_mod;
   logic       s1_re_s, s1_im_s;
   logic [2:0] s1_re_c, s1_im_c;

   logic [5:0] dat_q;
   logic       stb_q, cyc_q;

   assign halt    = stb_q & ~tx.ACK;
   assign beat    = rx.CYC & rx.STB & rx.WE;
   assign accept  = beat & ~halt;
   assign mod_cur = locked ? mod_lat : mod_t'(MOD);

   assign rx.ACK = accept;
   assign tx.DAT = dat_q;
   assign tx.STB = stb_q;
   assign tx.WE  = stb_q;
   assign tx.CYC = cyc_q;

   sym_slicer_axis u_re (.x(rx.DAT[15:0]),  .mod(mod_cur), .sgn(re_s), .cmp(re_c));
   sym_slicer_axis u_im (.x(rx.DAT[31:16]), .mod(mod_cur), .sgn(im_s), .cmp(im_c));

   function automatic logic [2:0] q64_bits(input logic s, input logic [2:0] c);
      return {s, c[1], ~c[0] | c[2]};
   endfunction

   function automatic logic [5:0] pack(input mod_t m, input logic rs, input logic [2:0] rc,
                                       input logic is, input logic [2:0] ic);
      logic [5:0] d;
      d = '0;
      case (m)
         MOD_Q64:  d = {q64_bits(is, ic), q64_bits(rs, rc)};
         MOD_Q16:  d = {2'b00, is, ic[0], rs, rc[0]};
         MOD_QPSK: d = {4'b0000, is, rs};
         MOD_BPSK: d = {5'b00000, is};
         default:  d = '0;
      endcase
      return d;
   endfunction

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         locked  <= 1'b0;
         mod_lat <= MOD_QPSK;
         s1_v    <= 1'b0;
         s1_mod  <= MOD_QPSK;
         s1_re_s <= 1'b0;
         s1_im_s <= 1'b0;
         s1_re_c <= '0;
         s1_im_c <= '0;
         dat_q   <= '0;
         stb_q   <= 1'b0;
         cyc_q   <= 1'b0;
      end else begin
         // Close the output frame once nothing will be left in S1 or on the output
         cyc_q <= rx.CYC | halt | s1_v;

         if (!rx.CYC)
            locked <= 1'b0;
         else if (accept)
            locked <= 1'b1;
         if (accept && !locked)
            mod_lat <= mod_t'(MOD);

         if (!halt) begin
            s1_v <= accept;
            if (accept) begin
               s1_mod  <= mod_cur;
               s1_re_s <= re_s;
               s1_im_s <= im_s;
               s1_re_c <= re_c;
               s1_im_c <= im_c;
            end
            stb_q <= s1_v;
            if (s1_v)
               dat_q <= pack(s1_mod, s1_re_s, s1_re_c, s1_im_s, s1_im_c);
         end
      end
   end

endmodule

// File: tb/tb_sym_demod.sv
// Directed bench for sym_demod: single-beat vector table plus burst, mode-flip and reset sequences.
module tb_sym_demod;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mod;

   sym_demod_if #(.DW(32)) rx_if ();
   sym_demod_if #(.DW(6))  tx_if ();

   sym_demod dut (
      .CLK_I(clk),
      .RST_I(rst),
      .MOD  (mod),
      .rx   (rx_if),
      .tx   (tx_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0]  m;
      logic [31:0] d;
      logic [5:0]  e;
   } vec_t;

   vec_t        vecs[14];
   logic [1:0]  b_mod[8];
   logic [31:0] b_dat[8];
   logic [5:0]  b_exp[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_one(input vec_t v, input int idx);
      int   lat;
      logic got;
      @(posedge clk); #1;
      mod = v.m; rx_if.DAT = v.d; rx_if.CYC = 1'b1; rx_if.STB = 1'b1; rx_if.WE = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d ack_o", idx), rx_if.ACK, 1);
      check($sformatf("vec%0d cyc_o_idle", idx), tx_if.CYC, 0);
      @(posedge clk); #1;
      rx_if.CYC = 1'b0; rx_if.STB = 1'b0; rx_if.WE = 1'b0;
      lat = 0; got = 1'b0;
      for (int n = 1; n <= 10 && !got; n++) begin
         @(negedge clk);
         if (n == 1) check($sformatf("vec%0d cyc_o_rise", idx), tx_if.CYC, 1);
         if (tx_if.STB) begin got = 1'b1; lat = n; end
      end
      check($sformatf("vec%0d latency", idx), lat, 2);
      check($sformatf("vec%0d dat_o", idx), tx_if.DAT, v.e);
      check($sformatf("vec%0d we_o", idx), tx_if.WE, 1);
      @(negedge clk);
      check($sformatf("vec%0d stb_o_clear", idx), tx_if.STB, 0);
      check($sformatf("vec%0d cyc_o_fall", idx), tx_if.CYC, 0);
   endtask

   task automatic run_burst(input int n, input int stall_at, input int stall_len,
                            input int bubble_at, input string tag);
      int         rcv;
      int         stalls;
      int         sent;
      logic [5:0] got[8];
      rcv = 0; stalls = 0; sent = 0;
      fork
         begin
            int   cyc;
            logic bubbled;
            cyc = 0; bubbled = 1'b0;
            while (sent < n && cyc < 100) begin
               @(posedge clk); #1;
               mod = b_mod[sent]; rx_if.DAT = b_dat[sent];
               rx_if.CYC = 1'b1; rx_if.WE = 1'b1;
               if (sent == bubble_at && !bubbled) begin
                  rx_if.STB = 1'b0; bubbled = 1'b1;
               end else begin
                  rx_if.STB = 1'b1;
               end
               @(negedge clk);
               if (rx_if.STB && rx_if.ACK) sent++;
               else if (rx_if.STB) stalls++;
               cyc++;
            end
            @(posedge clk); #1;
            rx_if.CYC = 1'b0; rx_if.STB = 1'b0; rx_if.WE = 1'b0;
         end
         begin
            int c;
            c = 0;
            while (rcv < n && c < 100) begin
               @(posedge clk); #1;
               tx_if.ACK = !(c >= stall_at && c < stall_at + stall_len);
               @(negedge clk);
               if (tx_if.STB && tx_if.ACK) begin
                  got[rcv] = tx_if.DAT;
                  check($sformatf("%s cyc_o_open%0d", tag, rcv), tx_if.CYC, 1);
                  rcv++;
               end
               c++;
            end
            @(posedge clk); #1;
            tx_if.ACK = 1'b1;
            @(negedge clk);
            check($sformatf("%s cyc_o_close", tag), tx_if.CYC, 0);
            check($sformatf("%s stb_o_idle", tag), tx_if.STB, 0);
         end
      join
      check($sformatf("%s beats_sent", tag), sent, n);
      check($sformatf("%s beats_rcvd", tag), rcv, n);
      for (int k = 0; k < n && k < rcv; k++)
         check($sformatf("%s dat%0d", tag, k), got[k], b_exp[k]);
      if (stall_len > 0)
         check($sformatf("%s ack_o_dropped", tag), (stalls > 0), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int stb_seen;

      vecs[0]  = '{2'b11, 32'h9D3F_13C0, 6'b110_001};
      vecs[1]  = '{2'b10, 32'h796E_D786, 6'b000110};
      vecs[2]  = '{2'b10, 32'h8692_287A, 6'b001100};
      vecs[3]  = '{2'b00, 32'hA57E_5A82, 6'b000010};
      vecs[4]  = '{2'b01, 32'h8001_7FFF, 6'b000001};
      vecs[5]  = '{2'b11, 32'h0000_2780, 6'b001_001};
      vecs[6]  = '{2'b11, 32'h0000_2781, 6'b001_000};
      vecs[7]  = '{2'b11, 32'h0000_8000, 6'b001_111};
      vecs[8]  = '{2'b11, 32'h4F01_0000, 6'b000_001};
      vecs[9]  = '{2'b11, 32'h7160_4F02, 6'b010_010};
      vecs[10] = '{2'b11, 32'h8001_7161, 6'b111_011};
      vecs[11] = '{2'b10, 32'h50F5_50F4, 6'b000100};
      vecs[12] = '{2'b00, 32'hFFFF_0000, 6'b000010};
      vecs[13] = '{2'b01, 32'h0000_8000, 6'b000000};

      b_dat[0] = 32'h8002_13C0; b_exp[0] = 6'b111_001;
      b_dat[1] = 32'h9D3E_3B40; b_exp[1] = 6'b110_000;
      b_dat[2] = 32'hC4C0_62C2; b_exp[2] = 6'b100_010;
      b_dat[3] = 32'hEC40_7FFE; b_exp[3] = 6'b101_011;
      b_dat[4] = 32'h7FFE_EC40; b_exp[4] = 6'b011_101;
      b_dat[5] = 32'h62C2_C4C0; b_exp[5] = 6'b010_100;
      b_dat[6] = 32'h3B40_9D3E; b_exp[6] = 6'b000_110;
      b_dat[7] = 32'h13C0_8002; b_exp[7] = 6'b001_111;

      rst = 1'b1; mod = 2'b00;
      rx_if.DAT = '0; rx_if.CYC = 1'b0; rx_if.STB = 1'b0; rx_if.WE = 1'b0;
      tx_if.ACK = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset stb_o", tx_if.STB, 0);
      check("reset cyc_o", tx_if.CYC, 0);
      check("reset dat_o", tx_if.DAT, 0);
      check("reset ack_o", rx_if.ACK, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 14; i++)
         send_one(vecs[i], i);

      for (int k = 0; k < 8; k++) b_mod[k] = 2'b11;
      run_burst(8, 4, 3, -1, "bp");

      b_mod[0] = 2'b11;
      for (int k = 1; k < 8; k++) b_mod[k] = 2'b00;
      run_burst(8, -10, 0, 3, "modflip");

      // Two beats in flight (one held at the output by ACK_I=0), then reset
      @(posedge clk); #1;
      tx_if.ACK = 1'b0;
      mod = 2'b11; rx_if.DAT = b_dat[0];
      rx_if.CYC = 1'b1; rx_if.STB = 1'b1; rx_if.WE = 1'b1;
      @(negedge clk);
      check("rst ack_o beat0", rx_if.ACK, 1);
      @(posedge clk); #1;
      rx_if.DAT = b_dat[1];
      @(negedge clk);
      check("rst ack_o beat1", rx_if.ACK, 1);
      @(posedge clk); #1;
      rx_if.STB = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("rst stb_o before", tx_if.STB, 1);
      @(posedge clk); #1;
      rst = 1'b0; rx_if.CYC = 1'b0; rx_if.WE = 1'b0; tx_if.ACK = 1'b1;
      @(negedge clk);
      check("rst stb_o after", tx_if.STB, 0);
      check("rst cyc_o after", tx_if.CYC, 0);
      check("rst dat_o after", tx_if.DAT, 0);
      stb_seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (tx_if.STB) stb_seen++;
      end
      check("rst beats discarded", stb_seen, 0);

      send_one(vecs[0], 99);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
